// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared entry layout and helpers for the fetch queue
package fetch_queue_pkg;

  localparam int INSTR_W   = 32;
  localparam int PC_W      = 32;

  // Entry layout, LSB first: fp, ff, pred, pc, instr
  localparam int FP_LSB    = 0;
  localparam int FF_LSB    = 1;
  localparam int PRED_LSB  = 2;
  localparam int PC_LSB    = 3;
  localparam int INSTR_LSB = PC_LSB + PC_W;
  localparam int ENTRY_W   = INSTR_LSB + INSTR_W;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               pred;
    logic               ff;
    logic               fp;
  } fq_entry_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch-side and issue-side signals of the fetch queue
interface fetch_queue_if #(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH_W     = 3
);

  logic                      flush_i;
  logic                      fetch_valid_i;
  logic                      fetch_accept_o;
  logic [32*FETCH_WIDTH-1:0] fetch_instr_i;
  logic [31:0]               fetch_pc_i;
  logic [FETCH_WIDTH-1:0]    fetch_pred_branch_i;
  logic                      fetch_fault_fetch_i;
  logic                      fetch_fault_page_i;
  logic [ISSUE_WIDTH-1:0]    out_valid_o;
  logic [ISSUE_WIDTH-1:0]    out_accept_i;
  logic [32*ISSUE_WIDTH-1:0] out_instr_o;
  logic [32*ISSUE_WIDTH-1:0] out_pc_o;
  logic [ISSUE_WIDTH-1:0]    out_pred_taken_o;
  logic [ISSUE_WIDTH-1:0]    out_fault_fetch_o;
  logic [ISSUE_WIDTH-1:0]    out_fault_page_o;
  logic [DEPTH_W:0]          occupancy_o;

  modport slave (
    input  flush_i, fetch_valid_i, fetch_instr_i, fetch_pc_i, fetch_pred_branch_i,
           fetch_fault_fetch_i, fetch_fault_page_i, out_accept_i,
    output fetch_accept_o, out_valid_o, out_instr_o, out_pc_o, out_pred_taken_o,
           out_fault_fetch_o, out_fault_page_o, occupancy_o
  );

  modport master (
    output flush_i, fetch_valid_i, fetch_instr_i, fetch_pc_i, fetch_pred_branch_i,
           fetch_fault_fetch_i, fetch_fault_page_i, out_accept_i,
    input  fetch_accept_o, out_valid_o, out_instr_o, out_pc_o, out_pred_taken_o,
           out_fault_fetch_o, out_fault_page_o, occupancy_o
  );

endinterface

// File: rtl/fetch_queue_slot_compact.sv
// rtl/fetch_queue_slot_compact.sv - live-slot mask and compacted write offsets for one fetch bundle
module fq_slot_compact
  import fetch_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  localparam int W     = clog2(FETCH_WIDTH),
  localparam int IDX_W = (W > 0) ? W : 1,
  localparam int CNT_W = W + 1
) (
  input  logic [IDX_W-1:0]                   start,
  input  logic [FETCH_WIDTH-1:0]             pred,
  input  logic                               fault,
  output logic [FETCH_WIDTH-1:0]             live,
  output logic [FETCH_WIDTH-1:0][IDX_W-1:0]  widx,
  output logic [CNT_W-1:0]                   n_enq
);

  logic [CNT_W-1:0] cnt;
  logic             blocked;

  always_comb begin
    live    = '0;
    widx    = '0;
    cnt     = '0;
    blocked = 1'b0;
    if (fault) begin
      // A faulting bundle collapses to a single marker entry at the entry slot
      live[start] = 1'b1;
      cnt         = CNT_W'(1);
    end else begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if ((IDX_W'(k) >= start) && !blocked) begin
          live[k] = 1'b1;
          widx[k] = cnt[IDX_W-1:0];
          cnt     = cnt + CNT_W'(1);
          blocked = blocked | pred[k];
        end
      end
    end
    n_enq = cnt;
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular instruction queue between fetch and pre-decode
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8,
  parameter int DEPTH_W     = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_queue_if.slave  bus
);

  localparam int W     = clog2(FETCH_WIDTH);
  localparam int IDX_W = (W > 0) ? W : 1;
  localparam int CNT_W = W + 1;
  localparam logic [31:0] PC_LOW_MASK = 32'(FETCH_WIDTH * 4 - 1);

  logic [DEPTH_W-1:0] head_q, tail_q;
  logic [DEPTH_W:0]   count_q;
  logic [ENTRY_W-1:0] ram_q [DEPTH];

  logic [IDX_W-1:0]                  start;
  logic                              fault;
  logic [FETCH_WIDTH-1:0]            live;
  logic [FETCH_WIDTH-1:0][IDX_W-1:0] widx;
  logic [CNT_W-1:0]                  n_enq;
  logic [DEPTH_W+1:0]                free;
  logic                              fetch_accept;
  logic                              enq;
  logic [DEPTH_W:0]                  enq_n;
  logic [DEPTH_W:0]                  n_deq;
  fq_entry_t                         wr_entry [FETCH_WIDTH];

  logic [ISSUE_WIDTH-1:0]            lane_valid;
  logic [DEPTH_W-1:0]                rd_idx [ISSUE_WIDTH];
  logic [32*ISSUE_WIDTH-1:0]         lane_instr, lane_pc;
  logic [ISSUE_WIDTH-1:0]            lane_pred, lane_ff, lane_fp;

  generate
    if (W == 0) begin : g_start_single
      assign start = '0;
    end else begin : g_start_multi
      assign start = bus.fetch_pc_i[W+1:2];
    end
  endgenerate

  assign fault = bus.fetch_fault_fetch_i | bus.fetch_fault_page_i;

  fq_slot_compact #(.FETCH_WIDTH(FETCH_WIDTH)) u_compact (
    .start (start),
    .pred  (bus.fetch_pred_branch_i),
    .fault (fault),
    .live  (live),
    .widx  (widx),
    .n_enq (n_enq)
  );

  // Credit comes from the registered count only, so accept never depends on out_accept_i
  assign free         = (DEPTH_W+2)'(DEPTH) - {1'b0, count_q};
  assign fetch_accept = (free >= (DEPTH_W+2)'(FETCH_WIDTH));
  assign enq          = bus.fetch_valid_i & fetch_accept & ~bus.flush_i;
  assign enq_n        = enq ? (DEPTH_W+1)'(n_enq) : '0;

  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      wr_entry[k].instr = fault ? '0 : bus.fetch_instr_i[32*k +: 32];
      wr_entry[k].pc    = (bus.fetch_pc_i & ~PC_LOW_MASK) | 32'(k * 4);
      wr_entry[k].pred  = ~fault & bus.fetch_pred_branch_i[k];
      wr_entry[k].ff    = bus.fetch_fault_fetch_i;
      wr_entry[k].fp    = bus.fetch_fault_page_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (live[k]) ram_q[tail_q + DEPTH_W'(widx[k])] <= wr_entry[k];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      rd_idx[i]     = head_q + DEPTH_W'(i);
      lane_valid[i] = (count_q > (DEPTH_W+1)'(i)) & ~rst_i;
    end
  end

  always_comb begin
    lane_instr = '0;
    lane_pc    = '0;
    lane_pred  = '0;
    lane_ff    = '0;
    lane_fp    = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (lane_valid[i]) begin
        lane_instr[32*i +: 32] = ram_q[rd_idx[i]][INSTR_LSB +: INSTR_W];
        lane_pc[32*i +: 32]    = ram_q[rd_idx[i]][PC_LSB +: PC_W];
        lane_pred[i]           = ram_q[rd_idx[i]][PRED_LSB];
        lane_ff[i]             = ram_q[rd_idx[i]][FF_LSB];
        lane_fp[i]             = ram_q[rd_idx[i]][FP_LSB];
      end
    end
  end

  // Only the leading run of accepted valid lanes retires, keeping issue in order
  always_comb begin
    logic run;
    run   = 1'b1;
    n_deq = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      run = run & lane_valid[i] & bus.out_accept_i[i];
      if (run) n_deq = n_deq + (DEPTH_W+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + n_deq[DEPTH_W-1:0];
      tail_q  <= tail_q + enq_n[DEPTH_W-1:0];
      count_q <= count_q + enq_n - n_deq;
    end
  end

  assign bus.fetch_accept_o    = fetch_accept;
  assign bus.out_valid_o       = lane_valid;
  assign bus.out_instr_o       = lane_instr;
  assign bus.out_pc_o          = lane_pc;
  assign bus.out_pred_taken_o  = lane_pred;
  assign bus.out_fault_fetch_o = lane_ff;
  assign bus.out_fault_page_o  = lane_fp;
  assign bus.occupancy_o       = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed vector bench for fetch_queue
module tb_fetch_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.FETCH_WIDTH(2), .ISSUE_WIDTH(2), .DEPTH_W(3)) bus ();

  fetch_queue #(.FETCH_WIDTH(2), .ISSUE_WIDTH(2), .DEPTH(8), .DEPTH_W(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        rst, flush, fv;
    logic [31:0] pc, i0, i1;
    logic [1:0]  pred;
    logic        ff, fp;
    logic [1:0]  acc;
    logic [3:0]  occ;
    logic [1:0]  val;
    logic        fa;
    logic [31:0] pc0, pc1, in0;
    logic [1:0]  pt, fpg;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic r, logic fl, logic fv, logic [31:0] pc, logic [31:0] i0,
                              logic [31:0] i1, logic [1:0] pred, logic ff, logic fp,
                              logic [1:0] acc, logic [3:0] occ, logic [1:0] val, logic fa,
                              logic [31:0] pc0, logic [31:0] pc1, logic [31:0] in0,
                              logic [1:0] pt, logic [1:0] fpg);
    vec_t v;
    v.rst = r; v.flush = fl; v.fv = fv; v.pc = pc; v.i0 = i0; v.i1 = i1;
    v.pred = pred; v.ff = ff; v.fp = fp; v.acc = acc; v.occ = occ; v.val = val;
    v.fa = fa; v.pc0 = pc0; v.pc1 = pc1; v.in0 = in0; v.pt = pt; v.fpg = fpg;
    vq.push_back(v);
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic drive(logic fl, logic fv, logic [31:0] pc, logic [31:0] i0, logic [31:0] i1,
                       logic [1:0] pred, logic ff, logic fp, logic [1:0] acc);
    bus.flush_i             = fl;
    bus.fetch_valid_i       = fv;
    bus.fetch_pc_i          = pc;
    bus.fetch_instr_i       = {i1, i0};
    bus.fetch_pred_branch_i = pred;
    bus.fetch_fault_fetch_i = ff;
    bus.fetch_fault_page_i  = fp;
    bus.out_accept_i        = acc;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.occupancy_o > 4'd8) begin
      errors++;
      $display("FAIL occ_bound: got %0d expected <= 8", bus.occupancy_o);
    end
  end

  initial begin
    logic [31:0] epc;

    bus.flush_i = 1'b0; bus.fetch_valid_i = 1'b0; bus.fetch_pc_i = '0; bus.fetch_instr_i = '0;
    bus.fetch_pred_branch_i = '0; bus.fetch_fault_fetch_i = 1'b0; bus.fetch_fault_page_i = 1'b0;
    bus.out_accept_i = '0;

    //   rst fl fv pc            i0            i1            pr ff fp acc occ val fa pc0           pc1           in0           pt fpg
    add(1, 0, 1, 32'h80000000, 32'hA0000000, 32'hA0000001, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        0, 0);
    add(1, 0, 1, 32'h80000000, 32'hA0000000, 32'hA0000001, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 0, 1, 32'h80000000, 32'h00B00093, 32'h00100113, 0, 0, 0, 0, 2, 3, 1, 32'h80000000, 32'h80000004, 32'h00B00093, 0, 0);
    add(0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 3, 0, 0, 1, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 0, 1, 32'h80000004, 32'h11111111, 32'h22222222, 0, 0, 0, 0, 1, 1, 1, 32'h80000004, 32'h0,        32'h22222222, 0, 0);
    add(0, 0, 1, 32'h80000010, 32'h33333333, 32'h44444444, 1, 0, 0, 0, 2, 3, 1, 32'h80000004, 32'h80000010, 32'h22222222, 2, 0);
    add(0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 1, 1, 1, 1, 32'h80000010, 32'h0,        32'h33333333, 1, 0);
    add(0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 1, 0, 0, 1, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 0, 1, 32'h80000100, 32'hB0000000, 32'hB0000001, 0, 0, 0, 0, 2, 3, 1, 32'h80000100, 32'h80000104, 32'hB0000000, 0, 0);
    add(0, 0, 1, 32'h80000108, 32'hB0000002, 32'hB0000003, 0, 0, 0, 0, 4, 3, 1, 32'h80000100, 32'h80000104, 32'hB0000000, 0, 0);
    add(0, 0, 1, 32'h80000110, 32'hB0000004, 32'hB0000005, 0, 0, 0, 0, 6, 3, 1, 32'h80000100, 32'h80000104, 32'hB0000000, 0, 0);
    add(0, 0, 1, 32'h80000118, 32'hB0000006, 32'hB0000007, 0, 0, 0, 0, 8, 3, 0, 32'h80000100, 32'h80000104, 32'hB0000000, 0, 0);
    add(0, 0, 1, 32'h80000120, 32'hC0000000, 32'hC0000001, 0, 0, 0, 0, 8, 3, 0, 32'h80000100, 32'h80000104, 32'hB0000000, 0, 0);
    add(0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 2, 8, 3, 0, 32'h80000100, 32'h80000104, 32'hB0000000, 0, 0);
    add(0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 1, 7, 3, 0, 32'h80000104, 32'h80000108, 32'hB0000001, 0, 0);
    add(0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 3, 5, 3, 1, 32'h8000010C, 32'h80000110, 32'hB0000003, 0, 0);
    add(0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 3, 3, 3, 1, 32'h80000114, 32'h80000118, 32'hB0000005, 0, 0);
    add(0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 3, 1, 1, 1, 32'h8000011C, 32'h0,        32'hB0000007, 0, 0);
    add(0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 1, 0, 0, 1, 32'h0,        32'h0,        32'h0,        0, 0);

    foreach (vq[n]) begin
      rst = vq[n].rst;
      drive(vq[n].flush, vq[n].fv, vq[n].pc, vq[n].i0, vq[n].i1, vq[n].pred,
            vq[n].ff, vq[n].fp, vq[n].acc);
      chk($sformatf("v%0d.occ", n), 32'(bus.occupancy_o),      32'(vq[n].occ));
      chk($sformatf("v%0d.val", n), 32'(bus.out_valid_o),      32'(vq[n].val));
      chk($sformatf("v%0d.fa",  n), 32'(bus.fetch_accept_o),   32'(vq[n].fa));
      chk($sformatf("v%0d.pc0", n), bus.out_pc_o[31:0],        vq[n].pc0);
      chk($sformatf("v%0d.pc1", n), bus.out_pc_o[63:32],       vq[n].pc1);
      chk($sformatf("v%0d.in0", n), bus.out_instr_o[31:0],     vq[n].in0);
      chk($sformatf("v%0d.pt",  n), 32'(bus.out_pred_taken_o), 32'(vq[n].pt));
      chk($sformatf("v%0d.fpg", n), 32'(bus.out_fault_page_o), 32'(vq[n].fpg));
    end

    // Steady state: two in, two out every cycle
    drive(0, 1, 32'h80000200, 32'h200, 32'h204, 0, 0, 0, 0);
    chk("ss_fill_occ", 32'(bus.occupancy_o), 32'd2);
    for (int i = 0; i < 20; i++) begin
      epc = 32'h80000208 + 32'(8 * i);
      drive(0, 1, epc, epc, epc + 4, 0, 0, 0, 2'b11);
      chk($sformatf("ss%0d.occ", i), 32'(bus.occupancy_o), 32'd2);
      chk($sformatf("ss%0d.pc0", i), bus.out_pc_o[31:0],  epc);
      chk($sformatf("ss%0d.pc1", i), bus.out_pc_o[63:32], epc + 4);
    end
    drive(0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 2'b11);
    chk("ss_drain_occ", 32'(bus.occupancy_o), 32'd0);

    // Fault bundles collapse to one zeroed entry at the start slot
    drive(0, 1, 32'h80000008, 32'hDEADBEEF, 32'hCAFEF00D, 2'b01, 0, 1, 0);
    chk("pf.occ",   32'(bus.occupancy_o),      32'd1);
    chk("pf.val",   32'(bus.out_valid_o),      32'd1);
    chk("pf.in0",   bus.out_instr_o[31:0],     32'h0);
    chk("pf.pc0",   bus.out_pc_o[31:0],        32'h80000008);
    chk("pf.fpg",   32'(bus.out_fault_page_o), 32'd1);
    chk("pf.pt",    32'(bus.out_pred_taken_o), 32'd0);
    drive(0, 1, 32'h8000000C, 32'h12345678, 32'h9ABCDEF0, 0, 1, 0, 0);
    chk("bf.occ",   32'(bus.occupancy_o),       32'd2);
    chk("bf.pc1",   bus.out_pc_o[63:32],        32'h8000000C);
    chk("bf.in1",   bus.out_instr_o[63:32],     32'h0);
    chk("bf.ff",    32'(bus.out_fault_fetch_o), 32'd2);
    chk("bf.fpg",   32'(bus.out_fault_page_o),  32'd1);

    // Flush beats a same-cycle enqueue and dequeue
    drive(1, 1, 32'h80000300, 32'h1, 32'h2, 0, 0, 0, 2'b11);
    chk("fl.occ",   32'(bus.occupancy_o),    32'd0);
    chk("fl.val",   32'(bus.out_valid_o),    32'd0);
    chk("fl.fa",    32'(bus.fetch_accept_o), 32'd1);
    chk("fl.pc0",   bus.out_pc_o[31:0],      32'h0);
    drive(0, 1, 32'h80000300, 32'h1, 32'h2, 0, 0, 0, 0);
    chk("pf2.occ",  32'(bus.occupancy_o),    32'd2);
    chk("pf2.pc0",  bus.out_pc_o[31:0],      32'h80000300);
    chk("pf2.in1",  bus.out_instr_o[63:32],  32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
